tile_rom_responder: RTL and testbench
=====================================

Name: tile_rom_responder

Overview:
- SDRAM-side responder for tile-layer ROM fetch ports (sdr_req/sdr_addr/sdr_data/sdr_rdy).
- Accepts single-cycle fetch pulses from one layer and forwards them to the SDRAM controller channel.
- Returns each 32-bit tile row to the layer with a one-cycle ready pulse.
- One instance per layer; sits between the layer and the SDRAM arbiter port.

Parameters:
- BASE_ADDR, 25'h0, byte base of this layer's ROM region in SDRAM
- ADDR_W, 25, controller byte-address width

Ports:
- CLK_32M  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- sdr_req  in  1  one-cycle fetch pulse from the layer
- sdr_addr  in  20  32-bit word index, sampled when sdr_req=1
- sdr_data  out  32  returned row data, held between responses
- sdr_rdy  out  1  one-cycle pulse; sdr_data valid in the same cycle
- rom_loading  in  1  ROM download active; invalidates cache, blocks issue
- ram_addr  out  ADDR_W  byte address to controller
- ram_req  out  1  level request, held until acked
- ram_ack  in  1  one-cycle acknowledge; ram_data valid in the same cycle
- ram_data  in  32  controller read data
- overrun  out  1  sticky: a pending request was overwritten

Behaviour:
- Reset values: sdr_data=0, sdr_rdy=0, ram_req=0, ram_addr=0, overrun=0, pending empty, state IDLE.
- Reset mid-transaction abandons the request. An ack arriving after reset is ignored because ram_req=0.
- Address mapping: ram_addr = BASE_ADDR + {sdr_addr, 2'b00}, truncated to ADDR_W. Wrap-around is silent.
- ram_ack is sampled only while ram_req=1. A stray ack is ignored.
- States:
  - IDLE: ram_req=0. On sdr_req (and rom_loading=0), register ram_addr, ram_req=1 next cycle, go BUSY.
  - BUSY: ram_req held, ram_addr stable. On ram_ack: capture ram_data into sdr_data, sdr_rdy=1 next cycle, ram_req=0 next cycle, go IDLE.
- Latency:
  - sdr_req at t gives ram_req=1 at t+1.
  - ram_ack at t+1+k gives sdr_rdy at t+2+k.
  - Minimum 2 cycles (ack in the first ram_req cycle).
- Pending slot (1 deep):
  - sdr_req while BUSY is stored in pending.
  - A further sdr_req while pending is valid overwrites it (newest wins) and sets overrun.
- Back-to-back issue:
  - If pending is valid in IDLE, issue it next cycle. ram_req is low for exactly one cycle between transactions.
  - sdr_req coinciding with the ram_ack cycle goes to pending if pending is empty; otherwise it overwrites pending and sets overrun.
  - sdr_req in IDLE with pending valid: pending issues first, the new request becomes pending.
- rom_loading=1:
  - Suppresses new issue from IDLE; requests still enter pending.
  - An in-flight BUSY transaction completes normally.
  - Issue resumes the cycle after rom_loading falls.
- sdr_rdy never asserts on two consecutive cycles.

Optional Feature:
- Macro: TILE_ROM_RESP_CACHE_EN.
- Enabled:
  - One-entry cache holds {valid, word index, data} of the last completed fetch.
  - An sdr_req in IDLE whose word index equals the cached index (valid=1, pending empty) gets sdr_rdy with cached data at t+1, with no ram_req.
  - Cache valid clears on reset and whenever rom_loading=1.
- Disabled: every request goes to SDRAM. There is no cache storage and behaviour is exactly as above.

Decomposition:
- Shared package tile_rom_pkg:
  - word-index width (20) and data width (32) constants
  - typedef rom_req_t {addr[19:0]} for the pending slot
  - state enum {IDLE, BUSY}
- No sub-module. The cache is a small conditional block within the module.

Test Plan:
- Single fetch: sdr_req, addr=20'h00123, BASE_ADDR=25'h100000, ack after 3 cycles with ram_data=32'hDEADBEEF -> ram_addr=25'h10048C; sdr_rdy one cycle, sdr_data=DEADBEEF, held afterwards.
- Back-to-back: req A=1 at t, req B=2 at t+2 while BUSY -> A completes, ram_req low exactly one cycle, B issued at addr BASE+8; two sdr_rdy pulses in order A, B; overrun=0.
- Overrun: reqs A, B, C while A BUSY -> only A and C reach SDRAM; overrun=1 until reset.
- Reset mid-BUSY: RESET_N low while ram_req=1, then ack arrives -> ram_req=0, no sdr_rdy, sdr_data=0.
- rom_loading: hold 1, pulse sdr_req -> no ram_req. Drop rom_loading -> ram_req next cycle.
- Cache (macro on): fetch addr 5 twice -> second gives sdr_rdy at t+1, no ram_req. Pulse rom_loading, refetch 5 -> goes to SDRAM.

Source files
------------

// File: rtl/tile_rom_pkg.sv
// tile_rom_pkg: shared widths, pending-slot type and FSM states for tile_rom_responder.
package tile_rom_pkg;
  localparam int IDX_W  = 20;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [IDX_W-1:0] addr;
  } rom_req_t;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/tile_rom_responder.sv
// tile_rom_responder: bridges one tile layer's ROM fetch port onto an SDRAM controller channel.
// Optional one-entry row cache enabled by TILE_ROM_RESP_CACHE_EN.
module tile_rom_responder
  import tile_rom_pkg::*;
#(
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter int          ADDR_W    = 25
) (
  input  logic              CLK_32M,
  input  logic              RESET_N,
  input  logic              sdr_req,
  input  logic [IDX_W-1:0]  sdr_addr,
  output logic [DATA_W-1:0] sdr_data,
  output logic              sdr_rdy,
  input  logic              rom_loading,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_data,
  output logic              overrun
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] sdr_data_q, sdr_data_d;
  logic sdr_rdy_q, sdr_rdy_d, overrun_q, overrun_d, pend_vld_q, pend_vld_d;
  rom_req_t pend_q, pend_d;
  logic hit;
  logic [DATA_W-1:0] hit_data;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [IDX_W-1:0] a);
    return ADDR_W'(BASE_ADDR) + ADDR_W'({a, 2'b00});
  endfunction

`ifdef TILE_ROM_RESP_CACHE_EN
  logic c_vld_q, c_vld_d;
  logic [IDX_W-1:0] c_idx_q, c_idx_d, cur_q, cur_d;
  logic [DATA_W-1:0] c_data_q, c_data_d;
  // a hit right after a completion is sent to SDRAM so sdr_rdy never pulses twice in a row
  assign hit      = c_vld_q && (c_idx_q == sdr_addr) && !pend_vld_q && !sdr_rdy_q;
  assign hit_data = c_data_q;
  always_comb begin
    cur_d    = (state_q == IDLE && !rom_loading) ? (pend_vld_q ? pend_q.addr : sdr_addr) : cur_q;
    c_vld_d  = rom_loading ? 1'b0 : (state_q == BUSY && ram_ack) ? 1'b1 : c_vld_q;
    c_idx_d  = (state_q == BUSY && ram_ack) ? cur_q : c_idx_q;
    c_data_d = (state_q == BUSY && ram_ack) ? ram_data : c_data_q;
  end
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      c_vld_q  <= 1'b0;
      c_idx_q  <= '0;
      c_data_q <= '0;
      cur_q    <= '0;
    end else begin
      c_vld_q  <= c_vld_d;
      c_idx_q  <= c_idx_d;
      c_data_q <= c_data_d;
      cur_q    <= cur_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    sdr_data_d = sdr_data_q;
    sdr_rdy_d  = 1'b0;
    overrun_d  = overrun_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (state_q == IDLE) begin
      if (!rom_loading && pend_vld_q) begin
        state_d    = BUSY;
        ram_addr_d = map_addr(pend_q.addr);
        pend_vld_d = sdr_req;
        if (sdr_req) pend_d.addr = sdr_addr;
      end else if (sdr_req && !rom_loading && hit) begin
        sdr_rdy_d  = 1'b1;
        sdr_data_d = hit_data;
      end else if (sdr_req && !rom_loading) begin
        state_d    = BUSY;
        ram_addr_d = map_addr(sdr_addr);
      end else if (sdr_req) begin
        pend_vld_d  = 1'b1;
        pend_d.addr = sdr_addr;
        overrun_d   = overrun_q | pend_vld_q;
      end
    end else begin
      if (sdr_req) begin
        pend_vld_d  = 1'b1;
        pend_d.addr = sdr_addr;
        overrun_d   = overrun_q | pend_vld_q;
      end
      if (ram_ack) begin
        sdr_data_d = ram_data;
        sdr_rdy_d  = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      sdr_data_q <= '0;
      sdr_rdy_q  <= 1'b0;
      overrun_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      sdr_data_q <= sdr_data_d;
      sdr_rdy_q  <= sdr_rdy_d;
      overrun_q  <= overrun_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  assign ram_req  = (state_q == BUSY);
  assign ram_addr = ram_addr_q;
  assign sdr_data = sdr_data_q;
  assign sdr_rdy  = sdr_rdy_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_tile_rom_responder.sv
// tb_tile_rom_responder: directed self-checking bench for tile_rom_responder.
module tb_tile_rom_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sdr_req = 1'b0;
  logic [19:0] sdr_addr = '0;
  logic [31:0] sdr_data;
  logic sdr_rdy;
  logic rom_loading = 1'b0;
  logic [24:0] ram_addr;
  logic ram_req;
  logic ram_ack = 1'b0;
  logic [31:0] ram_data = '0;
  logic overrun;
  int checks = 0;
  int failures = 0;

  tile_rom_responder #(.BASE_ADDR(25'h100000), .ADDR_W(25)) dut (
    .CLK_32M(clk), .RESET_N(rst_n), .sdr_req(sdr_req), .sdr_addr(sdr_addr),
    .sdr_data(sdr_data), .sdr_rdy(sdr_rdy), .rom_loading(rom_loading),
    .ram_addr(ram_addr), .ram_req(ram_req), .ram_ack(ram_ack),
    .ram_data(ram_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic req(input logic [19:0] a);
    sdr_req = 1'b1;
    sdr_addr = a;
    tick();
    sdr_req = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d);
    ram_ack = 1'b1;
    ram_data = d;
    tick();
    ram_ack = 1'b0;
  endtask

  initial begin
    tick(); tick(); tick();
    chk("rst_sdr_data", sdr_data, 0);
    chk("rst_sdr_rdy", {31'b0, sdr_rdy}, 0);
    chk("rst_ram_req", {31'b0, ram_req}, 0);
    chk("rst_ram_addr", {7'b0, ram_addr}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    rst_n = 1'b1;
    tick();
    ram_ack = 1'b1; ram_data = 32'h55;
    tick();
    ram_ack = 1'b0;
    chk("stray_ack_rdy", {31'b0, sdr_rdy}, 0);
    chk("stray_ack_data", sdr_data, 0);
    // single fetch, ack after 3 ram_req cycles
    req(20'h00123);
    chk("single_ram_req", {31'b0, ram_req}, 1);
    chk("single_ram_addr", {7'b0, ram_addr}, 32'h10048C);
    tick(); tick();
    chk("single_req_held", {31'b0, ram_req}, 1);
    chk("single_addr_stable", {7'b0, ram_addr}, 32'h10048C);
    ack(32'hDEADBEEF);
    chk("single_rdy", {31'b0, sdr_rdy}, 1);
    chk("single_data", sdr_data, 32'hDEADBEEF);
    chk("single_req_drop", {31'b0, ram_req}, 0);
    tick();
    chk("single_rdy_pulse", {31'b0, sdr_rdy}, 0);
    chk("single_data_held", sdr_data, 32'hDEADBEEF);
    // back-to-back A=1, B=2
    req(20'h1);
    chk("b2b_a_addr", {7'b0, ram_addr}, 32'h100004);
    tick();
    req(20'h2);
    ack(32'hAAAA0001);
    chk("b2b_a_rdy", {31'b0, sdr_rdy}, 1);
    chk("b2b_a_data", sdr_data, 32'hAAAA0001);
    chk("b2b_gap", {31'b0, ram_req}, 0);
    tick();
    chk("b2b_b_req", {31'b0, ram_req}, 1);
    chk("b2b_b_addr", {7'b0, ram_addr}, 32'h100008);
    chk("b2b_no_double_rdy", {31'b0, sdr_rdy}, 0);
    ack(32'hBBBB0002);
    chk("b2b_b_rdy", {31'b0, sdr_rdy}, 1);
    chk("b2b_b_data", sdr_data, 32'hBBBB0002);
    chk("b2b_overrun", {31'b0, overrun}, 0);
    tick();
    // overrun: A, B, C while A busy
    req(20'h10);
    req(20'h11);
    chk("ovr_clear_before", {31'b0, overrun}, 0);
    req(20'h12);
    chk("ovr_set", {31'b0, overrun}, 1);
    ack(32'h10);
    chk("ovr_a_data", sdr_data, 32'h10);
    tick();
    chk("ovr_c_addr", {7'b0, ram_addr}, 32'h100048);
    ack(32'h12);
    chk("ovr_c_data", sdr_data, 32'h12);
    tick();
    chk("ovr_b_dropped", {31'b0, ram_req}, 0);
    chk("ovr_sticky", {31'b0, overrun}, 1);
    // reset while busy, then a late ack
    req(20'h20);
    chk("rstb_busy", {31'b0, ram_req}, 1);
    rst_n = 1'b0;
    #1;
    chk("rstb_req_low", {31'b0, ram_req}, 0);
    chk("rstb_overrun", {31'b0, overrun}, 0);
    tick();
    rst_n = 1'b1;
    ack(32'h77777777);
    chk("rstb_no_rdy", {31'b0, sdr_rdy}, 0);
    chk("rstb_data", sdr_data, 0);
    chk("rstb_req", {31'b0, ram_req}, 0);
    // rom_loading blocks issue until it falls
    rom_loading = 1'b1;
    req(20'h30);
    chk("load_blocked", {31'b0, ram_req}, 0);
    tick();
    chk("load_still_blocked", {31'b0, ram_req}, 0);
    rom_loading = 1'b0;
    tick();
    chk("load_resume", {31'b0, ram_req}, 1);
    chk("load_addr", {7'b0, ram_addr}, 32'h1000C0);
    ack(32'h30303030);
    chk("load_rdy", {31'b0, sdr_rdy}, 1);
    chk("load_data", sdr_data, 32'h30303030);
`ifdef TILE_ROM_RESP_CACHE_EN
    tick();
    req(20'h5);
    ack(32'hCAFE0005);
    tick();
    req(20'h5);
    chk("cache_hit_rdy", {31'b0, sdr_rdy}, 1);
    chk("cache_hit_data", sdr_data, 32'hCAFE0005);
    chk("cache_hit_no_req", {31'b0, ram_req}, 0);
    rom_loading = 1'b1;
    tick();
    rom_loading = 1'b0;
    req(20'h5);
    chk("cache_inval_req", {31'b0, ram_req}, 1);
    ack(32'hCAFE0006);
    chk("cache_refetch_data", sdr_data, 32'hCAFE0006);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
